// File: rtl/step_delta_tracker.sv
// step_delta_tracker: counts step/dir pulses over a start/stop segment, returns a signed delta.
// Optional saturation of mag/position with STEP_DELTA_TRACKER_SAT_EN; wraps when undefined.
`default_nettype none

module step_delta_tracker #(
  parameter int NUM_BITS = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       step_i,
  input  logic                       dir_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       out_rdy_i,
  output logic signed [NUM_BITS-1:0] delta_o,
  output logic                       out_valid_o,
  output logic                       busy_o,
  output logic                       dir_err_o,
  output logic signed [NUM_BITS-1:0] position_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

`ifdef STEP_DELTA_TRACKER_SAT_EN
  localparam logic [NUM_BITS-2:0] MAG_MAX = '1;
  localparam logic [NUM_BITS-1:0] POS_MAX = {1'b0, {(NUM_BITS-1){1'b1}}};
  localparam logic [NUM_BITS-1:0] POS_MIN = {1'b1, {(NUM_BITS-1){1'b0}}};
`endif

  state_t              state_q, state_d;
  logic                step_q;
  logic [NUM_BITS-2:0] mag_q, mag_d;
  logic                seg_dir_q, seg_dir_d;
  logic                seen_q, seen_d;
  logic                dir_err_q, dir_err_d;
  logic [NUM_BITS-1:0] delta_q, delta_d;
  logic [NUM_BITS-1:0] position_q, position_d;
  logic                step_ev;

  assign step_ev = step_i & ~step_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      step_q     <= 1'b1;
      mag_q      <= '0;
      seg_dir_q  <= 1'b0;
      seen_q     <= 1'b0;
      dir_err_q  <= 1'b0;
      delta_q    <= '0;
      position_q <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_i;
      mag_q      <= mag_d;
      seg_dir_q  <= seg_dir_d;
      seen_q     <= seen_d;
      dir_err_q  <= dir_err_d;
      delta_q    <= delta_d;
      position_q <= position_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    seg_dir_d  = seg_dir_q;
    seen_d     = seen_q;
    dir_err_d  = dir_err_q;
    delta_d    = delta_q;
    position_d = position_q;

    // Position follows every step regardless of segment state.
    if (step_ev) begin
`ifdef STEP_DELTA_TRACKER_SAT_EN
      if (!dir_i && (position_q != POS_MAX)) begin
        position_d = position_q + NUM_BITS'(1);
      end else if (dir_i && (position_q != POS_MIN)) begin
        position_d = position_q - NUM_BITS'(1);
      end
`else
      position_d = dir_i ? (position_q - NUM_BITS'(1)) : (position_q + NUM_BITS'(1));
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_COUNT;
          mag_d     = '0;
          seg_dir_d = 1'b0;
          seen_d    = 1'b0;
          dir_err_d = 1'b0;
        end
      end
      ST_COUNT: begin
        if (step_ev) begin
`ifdef STEP_DELTA_TRACKER_SAT_EN
          if (mag_q != MAG_MAX) begin
            mag_d = mag_q + (NUM_BITS-1)'(1);
          end
`else
          mag_d = mag_q + (NUM_BITS-1)'(1);
`endif
          if (!seen_q) begin
            seen_d    = 1'b1;
            seg_dir_d = dir_i;
          end else if (dir_i != seg_dir_q) begin
            dir_err_d = 1'b1;
          end
        end
        // Use next-state values so a step coinciding with stop is included.
        if (stop_i) begin
          state_d = ST_HOLD;
          delta_d = seg_dir_d ? -{1'b0, mag_d} : {1'b0, mag_d};
        end
      end
      ST_HOLD: begin
        if (out_rdy_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign delta_o     = delta_q;
  assign position_o  = position_q;
  assign dir_err_o   = dir_err_q;
  assign out_valid_o = (state_q == ST_HOLD);
  assign busy_o      = (state_q == ST_COUNT);

endmodule

`default_nettype wire

// File: tb/tb_step_delta_tracker.sv
// Bench for step_delta_tracker: directed segments, scoreboard checked by a handshake monitor.
`default_nettype none

module tb_step_delta_tracker;

  localparam int NUM_BITS = 8;

  logic                       clk;
  logic                       reset;
  logic                       step;
  logic                       dir;
  logic                       start;
  logic                       stop;
  logic                       out_rdy;
  logic signed [NUM_BITS-1:0] delta;
  logic                       out_valid;
  logic                       busy;
  logic                       dir_err;
  logic signed [NUM_BITS-1:0] position;

  int checks = 0;
  int errors = 0;
  int sb[$];

  step_delta_tracker #(.NUM_BITS(NUM_BITS)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .step_i      (step),
    .dir_i       (dir),
    .start_i     (start),
    .stop_i      (stop),
    .out_rdy_i   (out_rdy),
    .delta_o     (delta),
    .out_valid_o (out_valid),
    .busy_o      (busy),
    .dir_err_o   (dir_err),
    .position_o  (position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted transfer must match the oldest expected delta.
  always @(negedge clk) begin
    if (!reset && out_valid && out_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delta: got %0d, expected no transfer", delta);
      end else begin
        check("delta", int'(delta), sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  // All tasks start and end at a falling edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_step(input logic d);
    dir  = d;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_stop(input int exp);
    sb.push_back(exp);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; step = 1'b0; dir = 1'b0;
    start = 1'b0; stop = 1'b0; out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_delta", int'(delta), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dir_err", int'(dir_err), 0);
    check("rst_position", int'(position), 0);
    reset = 1'b0;
    @(negedge clk);

    // Stop in IDLE is ignored; start+stop together only starts.
    stop = 1'b1;
    @(negedge clk);
    check("idle_stop_ignored", int'(busy), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", int'(busy), 1);
    for (int i = 0; i < 3; i++) do_step(1'b1);
    do_stop(-3);
    check("t1_valid", int'(out_valid), 1);
    @(negedge clk);
    check("t1_valid_1cyc", int'(out_valid), 0);
    check("t1_position", int'(position), -3);

    do_start();
    for (int i = 0; i < 3; i++) do_step(1'b0);
    do_stop(3);
    @(negedge clk);
    do_start();
    for (int i = 0; i < 5; i++) do_step(1'b1);
    do_stop(-5);
    @(negedge clk);
    check("t2_position", int'(position), -5);

    do_start();
    do_step(1'b0);
    do_step(1'b0);
    check("t3_no_err_yet", int'(dir_err), 0);
    do_step(1'b1);
    check("t3_dir_err", int'(dir_err), 1);
    do_stop(3);
    @(negedge clk);
    check("t3_err_sticky", int'(dir_err), 1);
    do_start();
    check("t3_err_cleared", int'(dir_err), 0);
    do_stop(0);
    @(negedge clk);
    check("t3_position", int'(position), -4);

    // Step coincident with stop is included.
    do_start();
    do_step(1'b0);
    sb.push_back(2);
    dir = 1'b0; step = 1'b1; stop = 1'b1;
    @(negedge clk);
    step = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("stopstep_position", int'(position), -2);

    // Step coincident with start is not counted in mag.
    dir = 1'b1; step = 1'b1; start = 1'b1;
    @(negedge clk);
    step = 1'b0; start = 1'b0;
    @(negedge clk);
    do_stop(0);
    @(negedge clk);
    check("startstep_position", int'(position), -3);

    // Consumer stalls: HOLD keeps delta, ignores start, position still tracks.
    out_rdy = 1'b0;
    do_start();
    do_step(1'b0);
    do_stop(1);
    do_start();
    do_step(1'b1);
    do_step(1'b1);
    repeat (4) @(negedge clk);
    check("hold_valid", int'(out_valid), 1);
    check("hold_busy", int'(busy), 0);
    check("hold_delta_stable", int'(delta), 1);
    check("hold_position", int'(position), -4);
    out_rdy = 1'b1;
    @(negedge clk);
    check("hold_released", int'(out_valid), 0);
    check("hold_idle_busy", int'(busy), 0);

    // Overflow from a clean position.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_start();
    for (int i = 0; i < 130; i++) do_step(1'b0);
`ifdef STEP_DELTA_TRACKER_SAT_EN
    do_stop(127);
    @(negedge clk);
    check("ovf_position", int'(position), 127);
`else
    do_stop(2);
    @(negedge clk);
    check("ovf_position", int'(position), -126);
`endif

    // Asynchronous reset mid-segment, step held high across release.
    do_start();
    for (int i = 0; i < 4; i++) do_step(1'b0);
    step = 1'b1; dir = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_position", int'(position), 0);
    check("arst_delta", int'(delta), 0);
    check("arst_valid", int'(out_valid), 0);
    check("arst_dir_err", int'(dir_err), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("held_step_ignored", int'(position), 0);
    step = 1'b0;
    @(negedge clk);
    do_step(1'b0);
    check("post_reset_step", int'(position), 1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
